// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bridge: access formats, FSM states
// and the default memory window base.
package dmem_pkg;

  localparam logic [1:0] FMT_WORD = 2'b00;
  localparam logic [1:0] FMT_HALF = 2'b01;
  localparam logic [1:0] FMT_BYTE = 2'b10;
  localparam logic [1:0] FMT_RSVD = 2'b11;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the CPU data port and a 32-bit little-endian
// memory word: byte enables, store replication and load extract/extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [1:0]  byte_off,
  input  logic        load_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half out of the memory word.
  always_comb begin
    unique case (byte_off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
  end

  // Enables, replicated store data and extended load data per access size.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'h0;
    unique case (fmt)
      FMT_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      FMT_HALF: begin
        be        = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{load_signed & half_sel[15]}}, half_sel};
      end
      FMT_BYTE: begin
        be        = 4'b0001 << byte_off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{load_signed & byte_sel[7]}}, byte_sel};
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridge from the single-cycle CPU data port to a word-organised data memory
// with fixed read latency; rejects and logs illegal accesses.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | accepting requests; stores and zero-latency loads finish here
// RD_WAIT | load issued, counting down the memory latency while stalling
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DMEM_BASE_ADDR,
  parameter int          MEM_AW     = 11,
  parameter int          RD_LATENCY = 1,
  parameter int          ERRCNT_W   = 8
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdata,
  input  logic                cpu_r,
  input  logic                cpu_w,
  input  logic [1:0]          cpu_fmt,
  input  logic                cpu_load_signed,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_stall,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_be,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [31:0]         mem_rdata,
  output logic                err_valid,
  output logic [31:0]         err_addr,
  output logic [ERRCNT_W-1:0] err_count
);

  // Window end as 33 bits so a window touching 2^32 cannot wrap.
  localparam logic [32:0] WIN_END  = {1'b0, BASE_ADDR} + (33'd4 << MEM_AW);
  // Loaded on issue; the load completes when the count reaches zero.
  localparam logic [2:0]  CNT_LOAD = (RD_LATENCY > 0) ? 3'(RD_LATENCY - 1) : 3'd0;

  dmem_state_e state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;

  logic        req, in_range, aligned, legal, reject;
  logic [3:0]  lane_be;
  logic [31:0] lane_rdata;

  dmem_lane_align u_lane_align (
    .fmt         (cpu_fmt),
    .byte_off    (cpu_addr[1:0]),
    .load_signed (cpu_load_signed),
    .wdata       (cpu_wdata),
    .rdata       (mem_rdata),
    .be          (lane_be),
    .wdata_rep   (mem_wdata),
    .rdata_ext   (lane_rdata)
  );

  assign mem_addr = MEM_AW'((cpu_addr - BASE_ADDR) >> 2);

  // Legality of the presented request: one strobe, valid size, in window, aligned.
  always_comb begin
    req      = cpu_r | cpu_w;
    in_range = ({1'b0, cpu_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, cpu_addr} < WIN_END);
    unique case (cpu_fmt)
      FMT_WORD: aligned = (cpu_addr[1:0] == 2'b00);
      FMT_HALF: aligned = ~cpu_addr[0];
      FMT_BYTE: aligned = 1'b1;
      default:  aligned = 1'b0;
    endcase
    legal  = (cpu_r ^ cpu_w) && (cpu_fmt != FMT_RSVD) && in_range && aligned;
    reject = (state == IDLE) && req && !legal;
  end

  // State and latency counter register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a legal load on a latent memory enters RD_WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (legal && cpu_r && (RD_LATENCY > 0)) begin
          state_nxt = RD_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      RD_WAIT: begin
        if (cnt != 3'd0) cnt_nxt   = cnt - 3'd1;
        else             state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Memory strobes, stall and load result for the current state.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_be    = 4'b0000;
    cpu_stall = 1'b0;
    cpu_rdata = 32'h0;
    unique case (state)
      IDLE: begin
        if (legal) begin
          mem_be = lane_be;
          if (cpu_w) begin
            mem_we = 1'b1;
          end else begin
            mem_re = 1'b1;
            if (RD_LATENCY == 0) cpu_rdata = lane_rdata;
            else                 cpu_stall = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        mem_be = lane_be;
        if (cnt != 3'd0) cpu_stall = 1'b1;
        else             cpu_rdata = lane_rdata;
      end
      default: ;
    endcase
  end

  // Error pulse, last rejected address and saturating reject counter.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_addr  <= 32'h0;
      err_count <= '0;
    end else begin
      err_valid <= reject;
      if (reject) begin
        err_addr <= cpu_addr;
        if (err_count != {ERRCNT_W{1'b1}}) err_count <= err_count + ERRCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: three instances (read latency 0, 2, 3) each with a
// latency-accurate memory, checked against a byte-addressed shadow memory.
module tb_dmem_bridge;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          WIN  = 8192;

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [3];
  logic [31:0] cpu_addr  [3];
  logic [31:0] cpu_wdata [3];
  logic        cpu_r     [3];
  logic        cpu_w     [3];
  logic [1:0]  cpu_fmt   [3];
  logic        cpu_sgn   [3];
  logic [31:0] cpu_rdata [3];
  logic        cpu_stall [3];
  logic [10:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [3:0]  mem_be    [3];
  logic        mem_we    [3];
  logic        mem_re    [3];
  logic [31:0] mem_rdata [3];
  logic        err_valid [3];
  logic [31:0] err_addr  [3];
  logic [7:0]  err_count [3];

  logic [7:0] shadow [3][WIN];
  int         exp_err [3];
  int         n_checks = 0;
  int         n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = lat_of(g);
    logic [31:0] mem [2048];
    logic [7:0]  pv;
    logic [10:0] pa [8];

    dmem_bridge #(
      .BASE_ADDR(BASE), .MEM_AW(11), .RD_LATENCY(LAT), .ERRCNT_W(8)
    ) u_dut (
      .clk_in          (clk),
      .reset           (rst[g]),
      .cpu_addr        (cpu_addr[g]),
      .cpu_wdata       (cpu_wdata[g]),
      .cpu_r           (cpu_r[g]),
      .cpu_w           (cpu_w[g]),
      .cpu_fmt         (cpu_fmt[g]),
      .cpu_load_signed (cpu_sgn[g]),
      .cpu_rdata       (cpu_rdata[g]),
      .cpu_stall       (cpu_stall[g]),
      .mem_addr        (mem_addr[g]),
      .mem_wdata       (mem_wdata[g]),
      .mem_be          (mem_be[g]),
      .mem_we          (mem_we[g]),
      .mem_re          (mem_re[g]),
      .mem_rdata       (mem_rdata[g]),
      .err_valid       (err_valid[g]),
      .err_addr        (err_addr[g]),
      .err_count       (err_count[g])
    );

    initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
      pv = 8'h0;
      for (int i = 0; i < 8; i++) pa[i] = 11'h0;
    end

    always @(posedge clk) begin
      if (mem_we[g])
        for (int b = 0; b < 4; b++)
          if (mem_be[g][b]) mem[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      pv <= {pv[6:0], mem_re[g]};
      pa[0] <= mem_addr[g];
      for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
    end

    if (LAT == 0) begin : g_async
      assign mem_rdata[g] = mem[mem_addr[g]];
    end else begin : g_sync
      // Data is only valid in the single cycle LAT after the read strobe.
      assign mem_rdata[g] = pv[LAT-1] ? mem[pa[LAT-1]] : 32'h0BAD_F00D;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int fsize(input logic [1:0] f);
    case (f)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input int k, input int off, input int n, input bit sgn);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = shadow[k][off+i];
    if (sgn && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic drive(input int k, input logic r, input logic w, input logic [1:0] fmt,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    cpu_addr[k] = addr; cpu_wdata[k] = wd; cpu_fmt[k] = fmt;
    cpu_sgn[k] = sgn; cpu_r[k] = r; cpu_w[k] = w;
  endtask

  // Count stall cycles from the issue cycle; caller is at posedge+2 of cycle T.
  task automatic wait_load(input int k, output int ns);
    ns = 0;
    while (cpu_stall[k] && ns < 12) begin
      @(posedge clk); #2;
      ns++;
      check("re_in_wait", mem_re[k], 1'b0);
    end
  endtask

  task automatic access(input int k, input logic r, input logic w, input logic [1:0] fmt,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    longint      offl;
    int          off, n, ns;
    bit          legal, req;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    offl  = longint'({32'h0, addr}) - longint'({32'h0, BASE});
    n     = fsize(fmt);
    req   = r | w;
    legal = (r ^ w) && fmt != 2'b11 && offl >= 0 && offl < WIN && (offl % n == 0);
    off   = legal ? int'(offl) : 0;
    @(posedge clk); #1;
    drive(k, r, w, fmt, sgn, addr, wd);
    #1;
    if (!legal) begin
      check("rej_we", mem_we[k], 1'b0);
      check("rej_re", mem_re[k], 1'b0);
      check("rej_stall", cpu_stall[k], 1'b0);
      check("rej_rdata", cpu_rdata[k], 32'h0);
      check("rej_be", mem_be[k], 4'h0);
    end else begin
      ebe = 4'h0;
      for (int i = 0; i < n; i++) ebe[(off % 4) + i] = 1'b1;
      check("mem_addr", mem_addr[k], 32'(off / 4));
      if (w) begin
        for (int l = 0; l < 4; l++) ewd[8*l +: 8] = wd[8*(l % n) +: 8];
        check("st_we", mem_we[k], 1'b1);
        check("st_re", mem_re[k], 1'b0);
        check("st_be", mem_be[k], ebe);
        check("st_wdata", mem_wdata[k], ewd);
        check("st_stall", cpu_stall[k], 1'b0);
        for (int i = 0; i < n; i++) shadow[k][off+i] = wd[8*i +: 8];
      end else begin
        check("ld_re", mem_re[k], 1'b1);
        check("ld_we", mem_we[k], 1'b0);
        wait_load(k, ns);
        check("ld_stall_cycles", ns, lat_of(k));
        check("ld_rdata", cpu_rdata[k], ref_load(k, off, n, sgn));
      end
    end
    @(posedge clk); #1;
    cpu_r[k] = 1'b0; cpu_w[k] = 1'b0;
    #1;
    if (req && !legal) begin
      if (exp_err[k] < 255) exp_err[k]++;
      check("err_valid", err_valid[k], 1'b1);
      check("err_addr", err_addr[k], addr);
    end else begin
      check("err_quiet", err_valid[k], 1'b0);
    end
    check("err_count", err_count[k], exp_err[k]);
  endtask

  // Two legal loads with the second presented in the cycle after the first completes.
  task automatic load_pair(input int k, input logic [1:0] fmt, input logic sgn,
                           input logic [31:0] a1, input logic [31:0] a2);
    int ns;
    @(posedge clk); #1;
    drive(k, 1'b1, 1'b0, fmt, sgn, a1, 32'h0);
    #1;
    wait_load(k, ns);
    check("b2b_stall1", ns, lat_of(k));
    check("b2b_rdata1", cpu_rdata[k], ref_load(k, int'(a1 - BASE), fsize(fmt), sgn));
    @(posedge clk); #1;
    cpu_addr[k] = a2;
    #1;
    check("b2b_issue_stall", cpu_stall[k], lat_of(k) > 0);
    check("b2b_issue_re", mem_re[k], 1'b1);
    wait_load(k, ns);
    check("b2b_stall2", ns, lat_of(k));
    check("b2b_rdata2", cpu_rdata[k], ref_load(k, int'(a2 - BASE), fsize(fmt), sgn));
    @(posedge clk); #1;
    cpu_r[k] = 1'b0;
    #1;
    check("b2b_err_count", err_count[k], exp_err[k]);
  endtask

  task automatic hold_illegal(input int k, input int cycles);
    @(posedge clk); #1;
    drive(k, 1'b1, 1'b0, 2'b11, 1'b0, BASE, 32'h0);
    repeat (cycles) @(posedge clk);
    #1;
    cpu_r[k] = 1'b0;
    #1;
    exp_err[k] = (exp_err[k] + cycles > 255) ? 255 : exp_err[k] + cycles;
    check("hold_err_valid", err_valid[k], 1'b1);
    check("hold_err_count", err_count[k], exp_err[k]);
  endtask

  task automatic reset_mid_read(input int k);
    @(posedge clk); #1;
    drive(k, 1'b1, 1'b0, 2'b00, 1'b0, BASE + 32'h8, 32'h0);
    #1;
    check("rst_issue_stall", cpu_stall[k], 1'b1);
    @(posedge clk); #1;
    check("rst_wait_stall", cpu_stall[k], 1'b1);
    rst[k] = 1'b1;
    @(posedge clk); #1;
    rst[k] = 1'b0;
    cpu_r[k] = 1'b0;
    #1;
    exp_err[k] = 0;
    check("rst_stall", cpu_stall[k], 1'b0);
    check("rst_rdata", cpu_rdata[k], 32'h0);
    check("rst_err_count", err_count[k], 8'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) begin
      case ($urandom_range(0, 4))
        0:       return BASE - 32'd4;
        1:       return BASE - 32'd1;
        2:       return BASE + 32'(WIN);
        3:       return BASE + 32'(WIN) + $urandom_range(0, 100);
        default: return 32'hFFFF_FFFC;
      endcase
    end else if (sel == 1) begin
      return BASE + 32'(WIN - 32) + $urandom_range(0, 31);
    end
    return BASE + $urandom_range(0, 63);
  endfunction

  initial begin
    int sel, f;
    logic [1:0] fmt;
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; exp_err[k] = 0;
      drive(k, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < WIN; i++) shadow[k][i] = 8'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_stall0", cpu_stall[k], 1'b0);
      check("rst_we0", mem_we[k], 1'b0);
      check("rst_re0", mem_re[k], 1'b0);
      check("rst_be0", mem_be[k], 4'h0);
      check("rst_rdata0", cpu_rdata[k], 32'h0);
      check("rst_errv0", err_valid[k], 1'b0);
      check("rst_erra0", err_addr[k], 32'h0);
      check("rst_errc0", err_count[k], 8'h0);
    end

    // Latency 2: word and byte store/load, rejects and window edges.
    access(1, 0, 1, 2'b00, 0, 32'h1001_0008, 32'hDEAD_BEEF);
    access(1, 1, 0, 2'b00, 0, 32'h1001_0008, 32'h0);
    check("deadbeef_shadow", ref_load(1, 8, 4, 0), 32'hDEAD_BEEF);
    access(1, 0, 1, 2'b10, 0, 32'h1001_0003, 32'h0000_00A5);
    access(1, 1, 0, 2'b10, 1, 32'h1001_0003, 32'h0);
    access(1, 1, 0, 2'b10, 0, 32'h1001_0003, 32'h0);
    access(1, 1, 0, 2'b01, 0, 32'h1001_0001, 32'h0);
    access(1, 1, 1, 2'b00, 0, 32'h1001_0000, 32'h0);
    access(1, 0, 1, 2'b00, 0, 32'h1000_FFFC, 32'h1234_5678);
    access(1, 1, 0, 2'b00, 0, BASE + 32'd8192, 32'h0);
    access(1, 0, 1, 2'b00, 0, BASE + 32'd8188, 32'hCAFE_F00D);
    access(1, 1, 0, 2'b00, 0, BASE + 32'd8188, 32'h0);
    load_pair(1, 2'b00, 0, BASE + 32'h8, BASE + 32'd8188);

    // Latency 3: reset in the middle of a load, then a clean full-latency load.
    access(2, 0, 1, 2'b00, 0, BASE + 32'h8, 32'h0BAD_CAFE);
    reset_mid_read(2);
    access(2, 1, 0, 2'b00, 0, BASE + 32'h8, 32'h0);

    // Latency 0: signed half loads back to back, then counter saturation.
    access(0, 0, 1, 2'b00, 0, BASE + 32'h20, 32'h8001_7FFF);
    load_pair(0, 2'b01, 1, BASE + 32'h20, BASE + 32'h22);
    check("half_lo", ref_load(0, 32'h20, 2, 1), 32'h0000_7FFF);
    check("half_hi", ref_load(0, 32'h22, 2, 1), 32'hFFFF_8001);
    hold_illegal(0, 300);
    access(0, 0, 1, 2'b11, 0, BASE, 32'h0);

    // Randomized traffic on every latency.
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 80; t++) begin
        sel = $urandom_range(0, 7);
        f   = $urandom_range(0, 7);
        fmt = (f < 3) ? 2'b00 : (f < 5) ? 2'b01 : (f < 7) ? 2'b10 : 2'b11;
        a   = rand_addr();
        if ($urandom_range(0, 1) == 1 && fmt != 2'b11) a = a & ~(32'(fsize(fmt)) - 32'd1);
        access(k, (sel >= 3 && sel <= 6), (sel <= 2 || sel == 6), fmt,
               1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
